// File: rtl/line_mem_responder_pkg.sv
// rtl/line_mem_responder_pkg.sv - shared line-memory types and line geometry helpers
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } mem_state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } mem_op_t;

  localparam int DEF_CACHE_LINE_SIZE = 128;
  localparam int TIMER_WIDTH         = 8;

  function automatic int line_bytes(input int line_bits);
    return line_bits / 8;
  endfunction

  function automatic int offset_bits(input int line_bits);
    return $clog2(line_bits / 8);
  endfunction

endpackage

// File: rtl/line_mem_responder_if.sv
// rtl/line_mem_responder_if.sv - cache<->memory line request/response interface
interface line_mem_responder_if #(
  parameter int CACHE_LINE_SIZE = 128
);
  logic                       in_mem_read_en;
  logic                       in_mem_write_en;
  logic [31:0]                in_mem_addr;
  logic [CACHE_LINE_SIZE-1:0] in_mem_write_data;
  logic [CACHE_LINE_SIZE-1:0] out_mem_read_data;
  logic                       out_mem_ready;
  logic                       out_mem_busy;

  modport master (
    output in_mem_read_en, in_mem_write_en, in_mem_addr, in_mem_write_data,
    input  out_mem_read_data, out_mem_ready, out_mem_busy
  );

  modport slave (
    input  in_mem_read_en, in_mem_write_en, in_mem_addr, in_mem_write_data,
    output out_mem_read_data, out_mem_ready, out_mem_busy
  );
endinterface

// File: rtl/line_mem_responder_mem_latency_timer.sv
// rtl/line_mem_responder_mem_latency_timer.sv - loadable down-counter with zero flag
module mem_latency_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic             zero
);
  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_value;
    end else if (dec && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign zero = (count_q == '0);
endmodule

// File: rtl/line_mem_responder.sv
// rtl/line_mem_responder.sv - fixed-latency whole-line memory responder below the data cache
// Optional LINE_MEM_PERF_CNT_EN adds read/write completion counters.
module line_mem_responder
  import mem_pkg::*;
#(
  parameter int CACHE_LINE_SIZE = DEF_CACHE_LINE_SIZE,
  parameter int MEM_BYTES       = 1024,
  parameter int LATENCY         = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  line_mem_responder_if.slave  bus
`ifdef LINE_MEM_PERF_CNT_EN
  ,
  output logic [31:0]          out_read_count,
  output logic [31:0]          out_write_count
`endif
);
  localparam int LINE_BYTES  = line_bytes(CACHE_LINE_SIZE);
  localparam int OFFSET_BITS = offset_bits(CACHE_LINE_SIZE);
  localparam int ADDR_BITS   = $clog2(MEM_BYTES);

  mem_state_t                 state_q, state_d;
  mem_op_t                    op_q;
  logic [ADDR_BITS-1:0]       base_q;
  logic [CACHE_LINE_SIZE-1:0] wdata_q;
  logic [CACHE_LINE_SIZE-1:0] rdata_q;
  logic [CACHE_LINE_SIZE-1:0] line_rd;
  logic [7:0]                 memory [0:MEM_BYTES-1];

  logic accept, timer_load, timer_dec, timer_zero, commit;
  logic ready, busy;
  logic unused_addr_bits;

  // Offset bits and anything above the array size fold away: wrap-around addressing.
  assign unused_addr_bits = ^{bus.in_mem_addr[31:ADDR_BITS], bus.in_mem_addr[OFFSET_BITS-1:0]};

  mem_latency_timer #(.WIDTH(TIMER_WIDTH)) u_timer (
    .clk        (clk),
    .rst_n      (reset),
    .load       (timer_load),
    .load_value (TIMER_WIDTH'(LATENCY - 1)),
    .dec        (timer_dec),
    .zero       (timer_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    timer_load = 1'b0;
    timer_dec  = 1'b0;
    ready      = 1'b0;
    busy       = 1'b1;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (bus.in_mem_read_en || bus.in_mem_write_en) begin
          accept     = 1'b1;
          timer_load = 1'b1;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (timer_zero) state_d = RESP;
        else            timer_dec = 1'b1;
      end
      RESP: begin
        ready   = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        // Stay here while the request is still held so it is not serviced twice.
        if (!bus.in_mem_read_en && !bus.in_mem_write_en) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign commit = (state_q == WAIT) && timer_zero;

  always_comb begin
    line_rd = '0;
    for (int i = 0; i < LINE_BYTES; i++) begin
      line_rd[i*8 +: 8] = memory[base_q | ADDR_BITS'(i)];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q    <= OP_READ;
      base_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        op_q    <= bus.in_mem_write_en ? OP_WRITE : OP_READ;
        base_q  <= {bus.in_mem_addr[ADDR_BITS-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
        wdata_q <= bus.in_mem_write_data;
      end
      if (commit && (op_q == OP_READ)) rdata_q <= line_rd;
    end
  end

  // Storage has no reset so benches can preload it; an aborted write never reaches commit.
  always_ff @(posedge clk) begin
    if (commit && (op_q == OP_WRITE)) begin
      for (int i = 0; i < LINE_BYTES; i++) begin
        memory[base_q | ADDR_BITS'(i)] <= wdata_q[i*8 +: 8];
      end
    end
  end

`ifdef LINE_MEM_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_read_count  <= '0;
      out_write_count <= '0;
    end else if (commit) begin
      if (op_q == OP_WRITE) out_write_count <= out_write_count + 32'd1;
      else                  out_read_count  <= out_read_count + 32'd1;
    end
  end
`endif

  assign bus.out_mem_read_data = rdata_q;
  assign bus.out_mem_ready     = ready;
  assign bus.out_mem_busy      = busy;
endmodule
